// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward selector: Memory-stage result wins over Writeback,
// and register x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] rdM,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] rdW,
  input  logic                              regWriteM,
  input  logic                              regWriteW,
  output fwd_sel_t                          fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && (rdM != '0) && (rdM == rs)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && (rdW != '0) && (rdW == rs)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Forwarding, stall/flush control and data-memory wait sequencing for the
// five-stage RV32 core. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int MEM_TIMEOUT            = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic                              MemReqM_i,
  input  logic                              MemAckM_i,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic                              MemErr_o,
  output logic [31:0]                       StallCnt_o,
  output logic [31:0]                       FlushCnt_o,
  output hz_state_t                         State_o
);

  localparam int CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

  fwd_sel_t        fwdA, fwdB;
  hz_state_t       state, nextState;
  logic [CntW-1:0] waitCnt, nextCnt;
  logic            lwStall, memHold;

  hazard_fwd_sel #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) uFwdA (
    .rs(Rs1E_i), .rdM(RdM_i), .rdW(RdW_i),
    .regWriteM(RegWriteM_i), .regWriteW(RegWriteW_i), .fwdSel(fwdA)
  );

  hazard_fwd_sel #(.REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) uFwdB (
    .rs(Rs2E_i), .rdM(RdM_i), .rdW(RdW_i),
    .regWriteM(RegWriteM_i), .regWriteW(RegWriteW_i), .fwdSel(fwdB)
  );

  assign ForwardAE_o = fwdA;
  assign ForwardBE_o = fwdB;

  assign lwStall = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                   ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextCnt;
    end
  end

  // Memory handshake: MemReqM_i marks an access in M; the access completes in
  // the cycle MemAckM_i is high, and the pipeline advances at that edge.
  always_comb begin
    nextState = state;
    nextCnt   = waitCnt;
    memHold   = 1'b0;
    unique case (state)
      RUN: begin
        memHold = MemReqM_i && !MemAckM_i;
        nextCnt = '0;
        if (memHold) nextState = WAIT;
      end
      WAIT: begin
        memHold = !MemAckM_i;
        if (MemAckM_i) begin
          nextState = RUN;
          nextCnt   = '0;
        end else begin
          nextCnt = (waitCnt >= TimeoutVal) ? TimeoutVal : waitCnt + CntW'(1);
          if (nextCnt == TimeoutVal) nextState = ERR;
        end
      end
      ERR: begin
        memHold = 1'b1;
      end
      default: begin
        nextState = RUN;
        nextCnt   = '0;
      end
    endcase
  end

  // A held E stage keeps any taken branch, so flushes wait for the release.
  assign StallF_o = lwStall || memHold;
  assign StallD_o = lwStall || memHold;
  assign StallE_o = memHold;
  assign StallM_o = memHold;
  assign FlushW_o = memHold;
  assign FlushD_o = PCSrcE_i && !memHold;
  assign FlushE_o = (lwStall || PCSrcE_i) && !memHold;
  assign MemErr_o = (state == ERR);
  assign State_o  = state;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt, flushCnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (StallF_o && (stallCnt != '1)) stallCnt <= stallCnt + 32'd1;
      if (FlushE_o && (flushCnt != '1)) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign StallCnt_o = stallCnt;
  assign FlushCnt_o = flushCnt;
`else
  assign StallCnt_o = '0;
  assign FlushCnt_o = '0;
`endif

endmodule
